spi_follower: RTL and testbench

SPI follower (slave) endpoint that pairs with the leader-side clock generator and shifter in top.
- Receives ext_clk, cs and in (leader data) from an external leader.
- Oversamples them in the system clk domain, shifts frames of 8/16/24/32 bits MSB-first, and drives out back to the leader.
- Uses the same config byte layout as the leader, with a valid/ready word interface to the core logic.

---
 rtl/spi_follower.sv | 172 +++++++++++++++++
 tb/tb_spi_follower.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/spi_follower.sv
// SPI follower endpoint: the pins are oversampled in the clk domain and frames of 8/16/24/32 bits are shifted MSB-first.
// Optional macro SPI_FOLLOWER_ECHO_EN: on a tx underrun, the previous rx_data is sent back instead of zeros.
module spi_follower #(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_BITS    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          cfg,
  input  logic                ext_clk,
  input  logic                cs,
  input  logic                in,
  output logic                out,
  output logic                out_oe,
  input  logic [MAX_BITS-1:0] tx_data,
  input  logic                tx_valid,
  output logic                tx_ready,
  output logic [MAX_BITS-1:0] rx_data,
  output logic                rx_valid,
  output logic                tx_underrun,
  output logic                frame_abort
);
  localparam int CW = $clog2(MAX_BITS + 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE, HOLD} state_t;

  function automatic logic [CW-1:0] frame_bits(input logic [1:0] len);
    int unsigned n;
    n = 8 * (int'(len) + 1);
    if (n > MAX_BITS) n = MAX_BITS;
    return CW'(n);
  endfunction

  logic [SYNC_STAGES-1:0] sclk_reg, scs_reg, sin_reg;
  logic                   sclk_prev_reg, scs_prev_reg;
  logic [SYNC_STAGES:0]   fill_reg;
  logic                   armed_reg;

  state_t                 state_reg;
  logic                   cpol_reg, cpha_reg;
  logic [CW-1:0]          nbits_reg, count_reg;
  logic [MAX_BITS-1:0]    tx_shift_reg, rx_shift_reg;

  logic                   cfg_unused;
  assign cfg_unused = ^{cfg[7], cfg[2:0]};

  // fill_reg tracks when the chains hold real pin history, so a cs held low
  // through reset is never mistaken for a fresh falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_reg      <= {SYNC_STAGES{cfg[4]}};
      scs_reg       <= '1;
      sin_reg       <= '0;
      sclk_prev_reg <= cfg[4];
      scs_prev_reg  <= 1'b1;
      fill_reg      <= '0;
      armed_reg     <= 1'b0;
    end else begin
      sclk_reg      <= {sclk_reg[SYNC_STAGES-2:0], ext_clk};
      scs_reg       <= {scs_reg[SYNC_STAGES-2:0], cs};
      sin_reg       <= {sin_reg[SYNC_STAGES-2:0], in};
      sclk_prev_reg <= sclk_reg[SYNC_STAGES-1];
      scs_prev_reg  <= scs_reg[SYNC_STAGES-1];
      fill_reg      <= {fill_reg[SYNC_STAGES-1:0], 1'b1};
      armed_reg     <= armed_reg | (fill_reg[SYNC_STAGES] & scs_reg[SYNC_STAGES-1]);
    end
  end

  logic                clk_s, cs_s, in_s;
  logic                clk_edge, lead_edge, trail_edge, sample_edge, shift_edge;
  logic                cs_fall, cs_rise;
  logic [CW-1:0]       new_nbits, count_next;
  logic [MAX_BITS-1:0] underrun_word, load_word, load_aligned, rx_mask;

  assign clk_s       = sclk_reg[SYNC_STAGES-1];
  assign cs_s        = scs_reg[SYNC_STAGES-1];
  assign in_s        = sin_reg[SYNC_STAGES-1];
  assign clk_edge    = clk_s ^ sclk_prev_reg;
  assign lead_edge   = clk_edge & (sclk_prev_reg == cpol_reg);
  assign trail_edge  = clk_edge & (sclk_prev_reg != cpol_reg);
  assign sample_edge = cpha_reg ? trail_edge : lead_edge;
  assign shift_edge  = cpha_reg ? lead_edge : trail_edge;
  assign cs_fall     = armed_reg & scs_prev_reg & ~cs_s;
  assign cs_rise     = ~scs_prev_reg & cs_s;
  assign new_nbits   = frame_bits(cfg[6:5]);
  assign count_next  = count_reg + CW'(1);

`ifdef SPI_FOLLOWER_ECHO_EN
  assign underrun_word = rx_data;
`else
  assign underrun_word = '0;
`endif

  // The tx word is left-aligned so the outgoing bit is always the shifter MSB.
  assign load_word    = tx_valid ? tx_data : underrun_word;
  assign load_aligned = load_word << (CW'(MAX_BITS) - new_nbits);
  assign rx_mask      = {MAX_BITS{1'b1}} >> (CW'(MAX_BITS) - nbits_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      out          <= 1'b0;
      out_oe       <= 1'b0;
      tx_ready     <= 1'b0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      tx_underrun  <= 1'b0;
      frame_abort  <= 1'b0;
      cpol_reg     <= 1'b0;
      cpha_reg     <= 1'b0;
      nbits_reg    <= CW'(MAX_BITS);
      count_reg    <= '0;
      tx_shift_reg <= '0;
      rx_shift_reg <= '0;
    end else begin
      tx_ready    <= 1'b0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      frame_abort <= 1'b0;
      unique case (state_reg)
        IDLE: begin
          out_oe <= 1'b0;
          if (cs_fall) begin
            cpol_reg     <= cfg[4];
            cpha_reg     <= cfg[3];
            nbits_reg    <= new_nbits;
            count_reg    <= '0;
            rx_shift_reg <= '0;
            tx_ready     <= tx_valid;
            tx_underrun  <= ~tx_valid;
            out_oe       <= 1'b1;
            state_reg    <= ACTIVE;
            if (!cfg[3]) begin
              out          <= load_aligned[MAX_BITS-1];
              tx_shift_reg <= load_aligned << 1;
            end else begin
              out          <= 1'b0;
              tx_shift_reg <= load_aligned;
            end
          end
        end
        ACTIVE: begin
          if (cs_rise) begin
            frame_abort <= 1'b1;
            out_oe      <= 1'b0;
            state_reg   <= IDLE;
          end else if (sample_edge) begin
            rx_shift_reg <= {rx_shift_reg[MAX_BITS-2:0], in_s};
            count_reg    <= count_next;
            if (count_next == nbits_reg) state_reg <= DONE;
          end else if (shift_edge) begin
            out          <= tx_shift_reg[MAX_BITS-1];
            tx_shift_reg <= tx_shift_reg << 1;
          end
        end
        DONE: begin
          rx_data   <= rx_shift_reg & rx_mask;
          rx_valid  <= 1'b1;
          state_reg <= HOLD;
        end
        HOLD: begin
          // Level test also catches a cs rise that landed during DONE.
          if (cs_s) begin
            out_oe    <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_follower.sv
// Directed bench for spi_follower: a leader model drives frames, and a monitor scoreboards the DUT pulses.
module tb_spi_follower;
  localparam int HALF = 4;
  localparam int EV_READY = 0, EV_UNDER = 1, EV_RX = 2, EV_ABORT = 3;

  logic        clk = 0, rst = 1;
  logic [7:0]  cfg = 8'h03;
  logic        ext_clk = 0, cs = 1, din = 0;
  logic        dout, dout_oe;
  logic [31:0] tx_data = 0;
  logic        tx_valid = 0;
  logic        tx_ready, rx_valid, tx_underrun, frame_abort;
  logic [31:0] rx_data;

  spi_follower #(.SYNC_STAGES(2), .MAX_BITS(32)) dut (
    .clk(clk), .rst(rst), .cfg(cfg), .ext_clk(ext_clk), .cs(cs), .in(din),
    .out(dout), .out_oe(dout_oe), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_underrun(tx_underrun), .frame_abort(frame_abort));

  always #5 clk = ~clk;

  typedef struct {int kind; logic [31:0] data;} ev_t;
  ev_t exp_q[$];
  int n_checks = 0, n_fail = 0;
  logic [31:0] last_rx = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_ev(input int kind, input logic [31:0] data);
    ev_t e;
    e.kind = kind;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic pop_ev(input int kind, input logic [31:0] data);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d data %h expected none", kind, data);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.data !== data) begin
        n_fail++;
        $display("FAIL event: got kind %0d data %h expected kind %0d data %h",
                 kind, data, e.kind, e.data);
      end
    end
  endtask

  always @(negedge clk) begin
    if (tx_ready === 1'b1)    pop_ev(EV_READY, 32'h0);
    if (tx_underrun === 1'b1) pop_ev(EV_UNDER, 32'h0);
    if (rx_valid === 1'b1)    pop_ev(EV_RX, rx_data);
    if (frame_abort === 1'b1) pop_ev(EV_ABORT, 32'h0);
  end

  // ending: 0 = full frame, 1 = abort by cs, 2 = reset mid-frame
  task automatic spi_xfer(input logic [7:0] c, input int nb, input logic tv,
                          input logic [31:0] tx, input logic [31:0] mosi,
                          input int ncyc, input int max_edges, input int ending);
    logic        cpol, cpha;
    logic [31:0] miso, mask, exp_miso;
    int          edges;
    cpol = c[4];
    cpha = c[3];
    mask = (nb >= 32) ? 32'hFFFF_FFFF : ((32'h1 << nb) - 32'h1);
`ifdef SPI_FOLLOWER_ECHO_EN
    exp_miso = tv ? (tx & mask) : (last_rx & mask);
`else
    exp_miso = tv ? (tx & mask) : 32'h0;
`endif
    push_ev(tv ? EV_READY : EV_UNDER, 32'h0);
    if (ending == 0) push_ev(EV_RX, mosi & mask);
    if (ending == 1) push_ev(EV_ABORT, 32'h0);
    miso = 0;
    edges = 0;
    cfg = c;
    tx_data = tx;
    tx_valid = tv;
    ext_clk = cpol;
    repeat (8) @(negedge clk);
    cs = 0;
    if (!cpha) din = mosi[nb-1];
    repeat (HALF) @(negedge clk);
    cfg = c ^ 8'h78;  // scrambled mid-frame: must have no effect
    for (int i = 0; i < ncyc; i++) begin
      if (edges < max_edges) begin
        if (!cpha && i < nb) miso = {miso[30:0], dout};
        ext_clk = ~cpol;
        edges++;
        if (cpha && i < nb) din = mosi[nb-1-i];
      end
      repeat (HALF) @(negedge clk);
      if (edges < max_edges) begin
        if (cpha && i < nb) miso = {miso[30:0], dout};
        ext_clk = cpol;
        edges++;
        if (!cpha && i + 1 < nb) din = mosi[nb-2-i];
      end
      repeat (HALF) @(negedge clk);
    end
    if (ending == 2) begin
      rst = 1;
      @(negedge clk);
      rst = 0;
      chk("rst_out", {31'h0, dout}, 32'h0);
      chk("rst_out_oe", {31'h0, dout_oe}, 32'h0);
      chk("rst_rx_data", rx_data, 32'h0);
      chk("rst_pulses", {28'h0, tx_ready, rx_valid, tx_underrun, frame_abort}, 32'h0);
      last_rx = 0;
      repeat (20) @(negedge clk);
      chk("rst_idle_oe", {31'h0, dout_oe}, 32'h0);
    end
    cs = 1;
    tx_valid = 0;
    repeat (8) @(negedge clk);
    $display("frame cfg=%h bits=%0d mosi=%h leader_got=%h ending=%0d", c, nb, mosi, miso, ending);
    if (ending == 0) begin
      chk("leader_capture", miso, exp_miso);
      last_rx = mosi & mask;
    end
    cfg = c;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (5) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("reset_out", {31'h0, dout}, 32'h0);
    chk("reset_out_oe", {31'h0, dout_oe}, 32'h0);
    chk("reset_tx_ready", {31'h0, tx_ready}, 32'h0);
    chk("reset_rx_data", rx_data, 32'h0);
    chk("reset_rx_valid", {31'h0, rx_valid}, 32'h0);
    chk("reset_tx_underrun", {31'h0, tx_underrun}, 32'h0);
    chk("reset_frame_abort", {31'h0, frame_abort}, 32'h0);
    repeat (5) @(negedge clk);

    spi_xfer(8'h03, 8, 1'b1, 32'h0000_00A5, 32'h0000_003C, 8, 16, 0);   // mode 0 byte
    chk("rx_data_mode0", rx_data, 32'h0000_003C);
    spi_xfer(8'h03, 8, 1'b0, 32'h0000_00FF, 32'h0000_0081, 8, 16, 0);   // underrun
    spi_xfer(8'h38, 16, 1'b1, 32'h0000_BEEF, 32'h0000_1234, 16, 32, 0); // mode 3, 16-bit
    spi_xfer(8'h03, 8, 1'b1, 32'h0000_0077, 32'h0000_00FF, 8, 5, 1);    // abort after 5 edges
    chk("rx_data_after_abort", rx_data, 32'h0000_1234);
    spi_xfer(8'h03, 8, 1'b1, 32'h0000_0069, 32'h0000_00C3, 8, 16, 0);   // recovery frame
    spi_xfer(8'h63, 32, 1'b1, 32'hCAFE_F00D, 32'hDEAD_BEEF, 34, 68, 0); // 32-bit + 2 extra clocks
    chk("rx_data_32", rx_data, 32'hDEAD_BEEF);
    spi_xfer(8'h63, 32, 1'b1, 32'h1111_1111, 32'hFFFF_FFFF, 10, 20, 2); // reset mid-frame
    spi_xfer(8'h03, 8, 1'b1, 32'h0000_0096, 32'h0000_005A, 8, 16, 0);   // frame after reset
    chk("rx_data_after_reset", rx_data, 32'h0000_005A);

    repeat (10) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
